// File: rtl/o_reg_pkg.sv
// Shared constants for the o_reg accumulator bank: value width, saturation bounds,
// and the width of the FIFO occupancy counter.
// Latency: n/a (package). Backpressure: n/a.
package o_reg_pkg;

  localparam int F_WIDTH_DEF = 8;
  localparam int I_WIDTH_DEF = 8;
  localparam int W           = F_WIDTH_DEF + I_WIDTH_DEF;

  // Clamp bounds for the default value width.
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  // Counter must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/o_reg_sat_add.sv
// Signed W-bit adder; with OREG_SAT_EN it clamps to the signed range and flags it,
// otherwise it wraps modulo 2^W and the flag stays 0.
// Latency: combinational. Backpressure: none.
module o_reg_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         sat_o
);

`ifdef OREG_SAT_EN
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [W:0] sum_wide;

  // Add at W+1 bits; disagreeing top two bits mean the true sum left the W-bit range.
  always_comb begin
    sum_wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    sat_o    = 1'b0;
    sum_o    = sum_wide[W-1:0];
    if (sum_wide[W] != sum_wide[W-1]) begin
      sat_o = 1'b1;
      sum_o = sum_wide[W] ? MINV : MAXV;
    end
  end
`else
  // Plain modulo-2^W add.
  always_comb begin
    sum_o = a_i + b_i;
    sat_o = 1'b0;
  end
`endif

endmodule

// File: rtl/o_reg_acc_bank.sv
// N_CH-channel accumulator bank whose vector is committed into a DEPTH-entry show-ahead FIFO.
// Latency: push at edge k is visible on rd_valid_o/rd_data_o right after edge k.
// Backpressure: rd_ready_i stalls the drain; a push to a full FIFO without a pop is dropped and sets ovf_o.
// Optional: OREG_SAT_EN selects saturating accumulate (else wrap, sat_o stays 0).
module o_reg_acc_bank
  import o_reg_pkg::*;
#(
  parameter  int F_WIDTH = F_WIDTH_DEF,
  parameter  int I_WIDTH = I_WIDTH_DEF,
  parameter  int N_CH    = 4,
  parameter  int DEPTH   = 4,
  localparam int DW      = F_WIDTH + I_WIDTH,
  localparam int CW      = cnt_width(DEPTH)
) (
  input  logic               clk_i,
  input  logic               oreg_rst_i,
  input  logic [N_CH-1:0]    oreg_wr_en_i,
  input  logic               oreg_acc_i,
  input  logic [N_CH*DW-1:0] wr_data_i,
  input  logic               oreg_push_i,
  input  logic               rd_ready_i,
  output logic               rd_valid_o,
  output logic [N_CH*DW-1:0] rd_data_o,
  output logic [CW-1:0]      count_o,
  output logic               full_o,
  output logic               ovf_o,
  output logic [N_CH-1:0]    sat_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]      acc_q [N_CH];
  logic [DW-1:0]      acc_d [N_CH];
  logic [DW-1:0]      lane_w [N_CH];
  logic [DW-1:0]      sum_w [N_CH];
  logic [N_CH-1:0]    clamp_w;
  logic [N_CH*DW-1:0] acc_vec_w;
  logic [N_CH*DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [N_CH-1:0]    sat_q, sat_d;
  logic               rd_valid_w, pop_w, push_ok_w;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign lane_w[c]               = wr_data_i[c*DW +: DW];
    assign acc_vec_w[c*DW +: DW]   = acc_q[c];
    o_reg_sat_add #(.W(DW)) u_add (
      .a_i   (acc_q[c]),
      .b_i   (lane_w[c]),
      .sum_o (sum_w[c]),
      .sat_o (clamp_w[c])
    );
  end

  assign rd_valid_w = (count_q != '0);
  assign pop_w      = rd_valid_w & rd_ready_i;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok_w  = oreg_push_i & ((count_q < CW'(DEPTH)) | pop_w);

  // Next-state: accumulators, flags, pointers and occupancy.
  always_comb begin
    sat_d    = sat_q;
    ovf_d    = ovf_q | (oreg_push_i & ~push_ok_w);
    wr_ptr_d = push_ok_w ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_w     ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok_w, pop_w})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    for (int c = 0; c < N_CH; c++) begin
      acc_d[c] = acc_q[c];
      if (push_ok_w) begin
        // Committed vector leaves; a same-cycle strobe starts the next one from its lane.
        acc_d[c] = oreg_wr_en_i[c] ? lane_w[c] : '0;
      end else if (oreg_wr_en_i[c]) begin
        acc_d[c] = oreg_acc_i ? sum_w[c] : lane_w[c];
        sat_d[c] = sat_q[c] | (oreg_acc_i & clamp_w[c]);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (oreg_rst_i) begin
      for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sat_q    <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) acc_q[c] <= acc_d[c];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sat_q    <= sat_d;
    end
  end

  // FIFO storage; contents past count_q are never observed, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (!oreg_rst_i && push_ok_w) mem_q[wr_ptr_q] <= acc_vec_w;
  end

  assign rd_valid_o = rd_valid_w;
  assign rd_data_o  = rd_valid_w ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign full_o     = (count_q == CW'(DEPTH));
  assign ovf_o      = ovf_q;
  assign sat_o      = sat_q;

endmodule

// File: tb/tb_o_reg_acc_bank.sv
// Self-checking bench for o_reg_acc_bank with a queue-based reference model.
module tb_o_reg_acc_bank;
  import o_reg_pkg::*;

  localparam int NC = 4;
  localparam int D  = 4;
  localparam int CW = cnt_width(D);
  localparam int WV = NC * W;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [NC-1:0] we_i = '0;
  logic          am_i = 1'b0;
  logic [WV-1:0] wd_i = '0;
  logic          push_i = 1'b0;
  logic          rdy_i = 1'b0;
  logic          rd_valid;
  logic [WV-1:0] rd_data;
  logic [CW-1:0] count;
  logic          full, ovf;
  logic [NC-1:0] sat;

  int nchk = 0;
  int nerr = 0;

  // Reference model state.
  int            acc_m [NC];
  logic [WV-1:0] q_m [$];
  logic          ovf_m;
  logic [NC-1:0] sat_m;

  always #5 clk = ~clk;

  o_reg_acc_bank #(.F_WIDTH(8), .I_WIDTH(8), .N_CH(NC), .DEPTH(D)) dut (
    .clk_i(clk), .oreg_rst_i(rst_i), .oreg_wr_en_i(we_i), .oreg_acc_i(am_i),
    .wr_data_i(wd_i), .oreg_push_i(push_i), .rd_ready_i(rdy_i),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .count_o(count),
    .full_o(full), .ovf_o(ovf), .sat_o(sat)
  );

  function automatic logic [WV-1:0] mk(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Drive one cycle of inputs, advance the model, wait past the edge.
  task automatic cyc(input logic r, input logic [NC-1:0] we, input logic am,
                     input logic [WV-1:0] d, input logic p, input logic rdy);
    bit            pop, ok;
    int            lane, s;
    logic [WV-1:0] snap;
    rst_i = r; we_i = we; am_i = am; wd_i = d; push_i = p; rdy_i = rdy;
    if (r) begin
      for (int c = 0; c < NC; c++) acc_m[c] = 0;
      q_m.delete(); ovf_m = 1'b0; sat_m = '0;
    end else begin
      pop = (q_m.size() > 0) && rdy;
      ok  = p && ((q_m.size() < D) || pop);
      for (int c = 0; c < NC; c++) snap[c*W +: W] = W'(acc_m[c]);
      for (int c = 0; c < NC; c++) begin
        lane = int'($signed(d[c*W +: W]));
        if (ok) acc_m[c] = we[c] ? lane : 0;
        else if (we[c]) begin
          if (!am) acc_m[c] = lane;
          else begin
            s = acc_m[c] + lane;
`ifdef OREG_SAT_EN
            if (s > int'(SAT_MAX)) begin s = int'(SAT_MAX); sat_m[c] = 1'b1; end
            if (s < int'(SAT_MIN)) begin s = int'(SAT_MIN); sat_m[c] = 1'b1; end
`else
            s = s & 32'hFFFF;
            if (s >= 32768) s = s - 65536;
`endif
            acc_m[c] = s;
          end
        end
      end
      if (pop) void'(q_m.pop_front());
      if (ok) q_m.push_back(snap);
      else if (p) ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, '0, 0, '0, 0, 0);
    nchk++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    nchk++; if (count !== '0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", count); end
    nchk++; if ({full, ovf, sat} !== '0) begin nerr++; $display("FAIL reset_flags got=%b exp=0", {full, ovf, sat}); end
    nchk++; if (rd_data !== '0) begin nerr++; $display("FAIL reset_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_load_acc();
    cyc(1, '0, 0, '0, 0, 0);
    cyc(0, 4'b0001, 0, mk(16'h0100, 0, 0, 0), 0, 0);
    cyc(0, 4'b0001, 1, mk(16'h0080, 0, 0, 0), 0, 0);
    cyc(0, 4'b0001, 1, mk(16'h0080, 0, 0, 0), 0, 0);
    nchk++; if (rd_valid !== 1'b0) begin nerr++; $display("FAIL la_prepush_valid got=%b exp=0", rd_valid); end
    cyc(0, '0, 0, '0, 1, 0);
    nchk++; if (rd_valid !== 1'b1) begin nerr++; $display("FAIL la_valid got=%b exp=1", rd_valid); end
    nchk++; if (rd_data !== mk(16'h0200, 0, 0, 0)) begin nerr++; $display("FAIL la_data got=%h exp=%h", rd_data, mk(16'h0200, 0, 0, 0)); end
    // Push+pop on a one-entry FIFO: new head must be the cleared accumulator vector.
    cyc(0, '0, 0, '0, 1, 1);
    nchk++; if (count !== CW'(1)) begin nerr++; $display("FAIL la_cnt got=%0d exp=1", count); end
    nchk++; if (rd_data !== '0) begin nerr++; $display("FAIL la_cleared got=%h exp=0", rd_data); end
  endtask

  task automatic test_sat();
    logic [15:0] exp_l;
    logic        exp_s;
`ifdef OREG_SAT_EN
    exp_l = 16'h7FFF; exp_s = 1'b1;
`else
    exp_l = 16'h8100; exp_s = 1'b0;
`endif
    cyc(1, '0, 0, '0, 0, 0);
    cyc(0, 4'b0010, 0, mk(0, 16'h7F00, 0, 0), 0, 0);
    cyc(0, 4'b0010, 1, mk(0, 16'h0200, 0, 0), 0, 0);
    nchk++; if (sat !== {2'b00, exp_s, 1'b0}) begin nerr++; $display("FAIL sat_flag got=%b exp=%b", sat, {2'b00, exp_s, 1'b0}); end
    cyc(0, '0, 0, '0, 1, 0);
    nchk++; if (rd_data[W +: W] !== exp_l) begin nerr++; $display("FAIL sat_value got=%h exp=%h", rd_data[W +: W], exp_l); end
  endtask

  task automatic test_full_ovf();
    logic [WV-1:0] v [5];
    cyc(1, '0, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      v[i] = {$urandom, $urandom};
      cyc(0, 4'hF, 0, v[i], 0, 0);
      cyc(0, '0, 0, '0, 1, 0);
    end
    nchk++; if ({full, count} !== {1'b1, CW'(4)}) begin nerr++; $display("FAIL full_state got=%b/%0d exp=1/4", full, count); end
    v[4] = {$urandom, $urandom};
    cyc(0, 4'hF, 0, v[4], 0, 0);
    cyc(0, '0, 0, '0, 1, 0);
    nchk++; if ({ovf, count} !== {1'b1, CW'(4)}) begin nerr++; $display("FAIL drop_state got=%b/%0d exp=1/4", ovf, count); end
    nchk++; if (rd_data !== v[0]) begin nerr++; $display("FAIL drop_head got=%h exp=%h", rd_data, v[0]); end
    cyc(0, '0, 0, '0, 1, 1);
    nchk++; if ({ovf, count} !== {1'b1, CW'(4)}) begin nerr++; $display("FAIL pushpop_state got=%b/%0d exp=1/4", ovf, count); end
    for (int i = 1; i < 5; i++) begin
      nchk++; if (rd_data !== v[i]) begin nerr++; $display("FAIL drain_%0d got=%h exp=%h", i, rd_data, v[i]); end
      cyc(0, '0, 0, '0, 0, 1);
    end
    nchk++; if ({rd_valid, rd_data} !== '0) begin nerr++; $display("FAIL drain_empty got=%b/%h exp=0/0", rd_valid, rd_data); end
  endtask

  task automatic test_push_strobe();
    cyc(1, '0, 0, '0, 0, 0);
    cyc(0, 4'b0100, 0, mk(0, 0, 16'h0033, 0), 0, 0);
    cyc(0, 4'b0100, 1, mk(0, 0, 16'h0011, 0), 1, 0);
    nchk++; if (rd_data !== mk(0, 0, 16'h0033, 0)) begin nerr++; $display("FAIL ps_stored got=%h exp=%h", rd_data, mk(0, 0, 16'h0033, 0)); end
    cyc(0, '0, 0, '0, 1, 1);
    nchk++; if (rd_data !== mk(0, 0, 16'h0011, 0)) begin nerr++; $display("FAIL ps_newacc got=%h exp=%h", rd_data, mk(0, 0, 16'h0011, 0)); end
  endtask

  task automatic test_reset_mid();
    cyc(1, '0, 0, '0, 0, 0);
    cyc(0, 4'b0001, 0, mk(16'h7FFF, 0, 0, 0), 0, 0);
    cyc(0, 4'b0001, 1, mk(16'h7FFF, 0, 0, 0), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 4'hF, 0, {$urandom, $urandom}, 1, 0);
    cyc(0, '0, 0, '0, 0, 1);
    nchk++; if ({ovf, count} !== {1'b1, CW'(3)}) begin nerr++; $display("FAIL rm_pre got=%b/%0d exp=1/3", ovf, count); end
    cyc(1, 4'hF, 1, {$urandom, $urandom}, 1, 1);
    nchk++; if ({rd_valid, count, full, ovf, sat} !== '0) begin nerr++; $display("FAIL rm_state got=%b exp=0", {rd_valid, count, full, ovf, sat}); end
    nchk++; if (rd_data !== '0) begin nerr++; $display("FAIL rm_data got=%h exp=0", rd_data); end
    cyc(0, '0, 0, '0, 1, 0);
    nchk++; if (rd_data !== '0) begin nerr++; $display("FAIL rm_acc got=%h exp=0", rd_data); end
  endtask

  task automatic test_random();
    logic [WV-1:0] d, exp_d;
    logic [CW-1:0] exp_c;
    cyc(1, '0, 0, '0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      d = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) d = d & {NC{16'h0FFF}};
      cyc(($urandom_range(79, 0) == 0), 4'($urandom), ($urandom_range(9, 0) < 7), d,
          ($urandom_range(9, 0) < 4), ($urandom_range(9, 0) < 4));
      exp_c = CW'(q_m.size());
      exp_d = (q_m.size() > 0) ? q_m[0] : '0;
      nchk++;
      if ({rd_valid, count, full, ovf, sat, rd_data} !==
          {(q_m.size() > 0), exp_c, (q_m.size() == D), ovf_m, sat_m, exp_d}) begin
        nerr++;
        $display("FAIL rand_%0d got v=%b c=%0d f=%b o=%b s=%b d=%h exp v=%b c=%0d f=%b o=%b s=%b d=%h",
                 n, rd_valid, count, full, ovf, sat, rd_data,
                 (q_m.size() > 0), exp_c, (q_m.size() == D), ovf_m, sat_m, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_acc();
    test_sat();
    test_full_ovf();
    test_push_strobe();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/o_reg_acc_bank.md
Name: o_reg_acc_bank

Overview:
- Multi-channel successor to the single output register, for the PE-array output path.
- Holds N_CH per-channel partial-sum accumulators with load or accumulate modes and saturating add.
- On a commit, the whole channel vector is pushed into a DEPTH-entry output FIFO.
- The FIFO drains over a valid/ready interface, so the array can keep producing while downstream stalls.

Parameters:
- F_WIDTH, 8, fractional bits of each value.
- I_WIDTH, 8, integer bits of each value; W = F_WIDTH + I_WIDTH, signed two's complement.
- N_CH, 4, number of channels (accumulators); must be at least 1.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk_i  in  1  single clock; all state updates on posedge.
- oreg_rst_i  in  1  reset, synchronous, active-high.
- oreg_wr_en_i  in  N_CH  per-channel write strobe.
- oreg_acc_i  in  1  mode for all strobed channels: 0 = load, 1 = accumulate.
- wr_data_i  in  N_CH*W  channel c occupies bits [c*W +: W], signed.
- oreg_push_i  in  1  commit the accumulator vector into the FIFO.
- rd_ready_i  in  1  downstream accepts the head entry.
- rd_valid_o  out  1  FIFO not empty.
- rd_data_o  out  N_CH*W  head entry, same lane packing as wr_data_i.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.
- full_o  out  1  count_o == DEPTH.
- ovf_o  out  1  sticky flag: a push was dropped.
- sat_o  out  N_CH  sticky per-channel flag: saturation occurred.

Behaviour:
- Reset (synchronous, active-high): on any clock edge with oreg_rst_i=1, the following clear to 0 and all other inputs are ignored that cycle:
  - all accumulators, FIFO pointers, count_o, ovf_o, sat_o;
  - rd_valid_o=0, full_o=0, rd_data_o=0.
  - Reset mid-drain discards all stored entries.
- Accumulate stage, per channel c on oreg_wr_en_i[c]=1:
  - load (oreg_acc_i=0): acc[c] <= lane c.
  - accumulate (oreg_acc_i=1): acc[c] <= sat(acc[c] + lane c).
  - Sum is formed at W+1 bits and clamped to [-(2^(W-1)), 2^(W-1)-1]. A clamp sets sat_o[c].
  - Channels with the strobe low hold their value.
- Pop: rd_valid_o=1 and rd_ready_i=1 pops the head.
  - rd_data_o is show-ahead: it shows the head entry combinationally from the register array, with no read latency.
  - rd_data_o is 0 when the FIFO is empty.
- Push is accepted when count_o < DEPTH, or when a pop happens in the same cycle.
  - Accepted push: the current acc vector is written at the tail. The stored value is the pre-edge acc value and does not include that cycle's writes.
  - All accumulators then clear to 0, except channels strobed in the same cycle. Those take lane c in either mode, since load and accumulate-from-zero give the same result.
  - Latency: push at edge k makes rd_valid_o=1 after edge k.
- Dropped push (FIFO full, no pop that cycle):
  - FIFO is unchanged and ovf_o sets.
  - Accumulators are NOT cleared; the same-cycle strobes apply normally, so data is preserved for a retry.
- Push and pop in the same cycle:
  - count_o is unchanged.
  - Allowed when empty only if rd_valid_o=0, in which case there is no pop; the push is accepted.
- Pointers wrap modulo DEPTH. count_o is updated by +1 (push only), -1 (pop only), or 0.
- rd_ready_i with the FIFO empty has no effect.
- ovf_o and sat_o clear only on reset.

Optional Feature:
- Macro: OREG_SAT_EN.
- Defined: saturating add and sat_o behave as described above.
- Not defined: the add wraps modulo 2^W and sat_o is tied to 0. Port list is unchanged.

Decomposition:
- Package o_reg_pkg holds:
  - W computed from F_WIDTH and I_WIDTH;
  - the signed max/min constants SAT_MAX and SAT_MIN;
  - a localparam function for the count width.
- Sub-module o_reg_sat_add: combinational W-bit signed add with W+1 internal width, returning the clamped sum and a sat flag. It is instantiated N_CH times.
- The FIFO storage is inline in o_reg_acc_bank.

Test Plan (defaults, W=16, N_CH=4, DEPTH=4):
- Load ch0=0x0100, then accumulate 0x0080 twice, then push -> rd_data_o lane0=0x0200, rd_valid_o=1 one edge later, acc[0]=0.
- acc[1]=0x7F00, accumulate 0x0200 -> acc[1]=0x7FFF, sat_o[1]=1. With OREG_SAT_EN undefined -> 0x8100, sat_o=0.
- 4 pushes with rd_ready_i=0 -> full_o=1, count_o=4. 5th push -> ovf_o=1, count_o=4, accumulators keep their values.
- With the FIFO full, push and pop in the same cycle -> count_o stays 4, the oldest entry leaves, the new vector is at the tail, ovf_o unchanged.
- Push with oreg_wr_en_i[2]=1, lane2=0x0011 -> FIFO gets the old acc[2], and acc[2]=0x0011 afterwards.
- 3 entries stored, assert oreg_rst_i for one cycle -> count_o=0, rd_valid_o=0, rd_data_o=0, all flags 0.
